// File: rtl/logic_avalon_mm_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : logic_avalon_mm_watchdog (with package logic_avalon_mm_pkg)
// Description : Avalon-MM bridge with one outstanding transfer. Forwards
//               read/write commands from the master side (s_*) to the slave
//               side (m_*) and returns readdata/response unchanged. A transfer
//               that stays open for TIMEOUT cycles is closed towards the master
//               with RESPONSE_SLAVEERROR, so the master never stalls.
// Ports       : aclk, areset         clock, asynchronous active-high reset
//               s_address/s_read/s_write/s_writedata/s_byteenable
//                                    master command in
//               s_waitrequest        1 while a transfer is open
//               s_readdata/s_readdatavalid/s_writeresponsevalid/s_response
//                                    completion to master (registered)
//               m_address/m_writedata/m_byteenable/m_read/m_write
//                                    registered command to slave
//               m_waitrequest/m_readdata/m_readdatavalid/
//               m_writeresponsevalid/m_response
//                                    slave handshake and completion
//               timeout              one-cycle pulse per timed-out transfer
// Revision    : 1.0 - initial release
// ============================================================================

package logic_avalon_mm_pkg;
    typedef enum logic [1:0] {
        RESPONSE_OKAY        = 2'b00,
        RESPONSE_RESERVED    = 2'b01,
        RESPONSE_SLAVEERROR  = 2'b10,
        RESPONSE_DECODEERROR = 2'b11
    } response_t;
endpackage

module logic_avalon_mm_watchdog
    import logic_avalon_mm_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT          = 256,   // must be >= 2
    parameter int TIMER_WIDTH      = $clog2(TIMEOUT + 1)
) (
    input  logic                        aclk,
    input  logic                        areset,
    // master side
    input  logic [ADDRESS_WIDTH-1:0]    s_address,
    input  logic                        s_read,
    input  logic                        s_write,
    input  logic [DATA_WIDTH-1:0]       s_writedata,
    input  logic [BYTEENABLE_WIDTH-1:0] s_byteenable,
    output logic                        s_waitrequest,
    output logic [DATA_WIDTH-1:0]       s_readdata,
    output logic                        s_readdatavalid,
    output logic                        s_writeresponsevalid,
    output logic [1:0]                  s_response,
    // slave side
    output logic [ADDRESS_WIDTH-1:0]    m_address,
    output logic [DATA_WIDTH-1:0]       m_writedata,
    output logic [BYTEENABLE_WIDTH-1:0] m_byteenable,
    output logic                        m_read,
    output logic                        m_write,
    input  logic                        m_waitrequest,
    input  logic [DATA_WIDTH-1:0]       m_readdata,
    input  logic                        m_readdatavalid,
    input  logic                        m_writeresponsevalid,
    input  logic [1:0]                  m_response,
    // status
    output logic                        timeout
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_issue    = 2'd1;
    localparam logic [1:0] c_st_response = 2'd2;
    localparam logic [1:0] c_st_drain    = 2'd3;

    localparam logic [TIMER_WIDTH-1:0] c_timer_last = TIMER_WIDTH'(TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] c_timer_one  = TIMER_WIDTH'(1);

    logic [1:0]             r_state;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_is_read;      // type of the open command

    logic [1:0]             w_state_nxt;
    logic [TIMER_WIDTH-1:0] w_timer_nxt;
    logic                   w_capture;
    logic                   w_m_read_nxt;
    logic                   w_m_write_nxt;
    logic                   w_s_rdv_nxt;
    logic                   w_s_wrv_nxt;
    logic [DATA_WIDTH-1:0]  w_s_rdata_nxt;
    logic [1:0]             w_s_resp_nxt;
    logic                   w_timeout_nxt;

    logic                   w_accept;
    logic                   w_conflict;
    logic                   w_match;
    logic                   w_expiry;

    assign w_accept   = (r_state == c_st_idle) & (s_read ^ s_write);
    assign w_conflict = (r_state == c_st_idle) & s_read & s_write;
    // Only the strobe matching the open command counts as its completion.
    assign w_match    = r_is_read ? m_readdatavalid : m_writeresponsevalid;
    assign w_expiry   = (r_timer == c_timer_last);

    assign s_waitrequest = (r_state != c_st_idle);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                // If the slave takes the command in the expiry cycle its
                // response is still pending, so it must be drained.
                if (w_expiry) begin
                    w_state_nxt = m_waitrequest ? c_st_idle : c_st_drain;
                end else if (!m_waitrequest) begin
                    w_state_nxt = c_st_response;
                end
            end
            c_st_response: begin
                if (w_match) begin
                    w_state_nxt = c_st_idle;
                end else if (w_expiry) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_match || w_expiry) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic (results registered below)
    // ------------------------------------------------------------------
    always_comb begin
        w_timer_nxt   = '0;
        w_capture     = 1'b0;
        w_m_read_nxt  = m_read;
        w_m_write_nxt = m_write;
        w_s_rdv_nxt   = 1'b0;
        w_s_wrv_nxt   = 1'b0;
        w_s_rdata_nxt = s_readdata;
        w_s_resp_nxt  = s_response;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_capture     = 1'b1;
                    w_m_read_nxt  = s_read;
                    w_m_write_nxt = s_write;
                end else if (w_conflict) begin
                    // Ambiguous command: answered locally, never forwarded.
                    w_s_rdv_nxt   = 1'b1;
                    w_s_rdata_nxt = '0;
                    w_s_resp_nxt  = RESPONSE_DECODEERROR;
                end
            end
            c_st_issue: begin
                w_timer_nxt = r_timer + c_timer_one;
                if (w_expiry) begin
                    w_timer_nxt   = '0;
                    w_m_read_nxt  = 1'b0;
                    w_m_write_nxt = 1'b0;
                    w_s_rdv_nxt   = r_is_read;
                    w_s_wrv_nxt   = ~r_is_read;
                    w_s_rdata_nxt = '0;
                    w_s_resp_nxt  = RESPONSE_SLAVEERROR;
                    w_timeout_nxt = 1'b1;
                end else if (!m_waitrequest) begin
                    w_m_read_nxt  = 1'b0;
                    w_m_write_nxt = 1'b0;
                end
            end
            c_st_response: begin
                w_timer_nxt = r_timer + c_timer_one;
                // A completion in the expiry cycle takes priority.
                if (w_match) begin
                    w_s_rdv_nxt   = r_is_read;
                    w_s_wrv_nxt   = ~r_is_read;
                    w_s_rdata_nxt = r_is_read ? m_readdata : '0;
                    w_s_resp_nxt  = m_response;
                end else if (w_expiry) begin
                    w_timer_nxt   = '0;
                    w_s_rdv_nxt   = r_is_read;
                    w_s_wrv_nxt   = ~r_is_read;
                    w_s_rdata_nxt = '0;
                    w_s_resp_nxt  = RESPONSE_SLAVEERROR;
                    w_timeout_nxt = 1'b1;
                end
            end
            c_st_drain: begin
                w_timer_nxt = r_timer + c_timer_one;
            end
            default: begin
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_timer              <= '0;
            r_is_read            <= 1'b0;
            m_address            <= '0;
            m_writedata          <= '0;
            m_byteenable         <= '0;
            m_read               <= 1'b0;
            m_write              <= 1'b0;
            s_readdata           <= '0;
            s_readdatavalid      <= 1'b0;
            s_writeresponsevalid <= 1'b0;
            s_response           <= RESPONSE_OKAY;
            timeout              <= 1'b0;
        end else begin
            r_timer              <= w_timer_nxt;
            m_read               <= w_m_read_nxt;
            m_write              <= w_m_write_nxt;
            s_readdata           <= w_s_rdata_nxt;
            s_readdatavalid      <= w_s_rdv_nxt;
            s_writeresponsevalid <= w_s_wrv_nxt;
            s_response           <= w_s_resp_nxt;
            timeout              <= w_timeout_nxt;
            if (w_capture) begin
                r_is_read    <= s_read;
                m_address    <= s_address;
                m_writedata  <= s_writedata;
                m_byteenable <= s_byteenable;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_avalon_mm_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_avalon_mm_watchdog
// Description : Self-checking bench for logic_avalon_mm_watchdog (TIMEOUT=8).
//               A table of per-cycle vectors covers read, write, reserved
//               pass-through and decode error; hand-written sequences cover
//               timeouts, exact-expiry completion and reset mid-transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_avalon_mm_watchdog;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid, s_writeresponsevalid;
    logic [1:0]    s_response;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_writedata;
    logic [BW-1:0] m_byteenable;
    logic          m_read, m_write;
    logic          m_waitrequest;
    logic [DW-1:0] m_readdata;
    logic          m_readdatavalid, m_writeresponsevalid;
    logic [1:0]    m_response;
    logic          timeout;

    logic_avalon_mm_watchdog #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .BYTEENABLE_WIDTH(BW),
        .TIMEOUT         (TO)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .s_address           (s_address),
        .s_read              (s_read),
        .s_write             (s_write),
        .s_writedata         (s_writedata),
        .s_byteenable        (s_byteenable),
        .s_waitrequest       (s_waitrequest),
        .s_readdata          (s_readdata),
        .s_readdatavalid     (s_readdatavalid),
        .s_writeresponsevalid(s_writeresponsevalid),
        .s_response          (s_response),
        .m_address           (m_address),
        .m_writedata         (m_writedata),
        .m_byteenable        (m_byteenable),
        .m_read              (m_read),
        .m_write             (m_write),
        .m_waitrequest       (m_waitrequest),
        .m_readdata          (m_readdata),
        .m_readdatavalid     (m_readdatavalid),
        .m_writeresponsevalid(m_writeresponsevalid),
        .m_response          (m_response),
        .timeout             (timeout)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {s_waitrequest, s_readdatavalid, s_writeresponsevalid, m_read, m_write, timeout}
    function automatic logic [5:0] ctl();
        return {s_waitrequest, s_readdatavalid, s_writeresponsevalid, m_read, m_write, timeout};
    endfunction

    typedef struct {
        logic          rd, wr;
        logic [31:0]   addr, wdata;
        logic [3:0]    be;
        logic          mw, mrdv, mwrv;
        logic [31:0]   mrdata;
        logic [1:0]    mresp;
        logic [5:0]    ectl;
        logic [31:0]   erdata;
        logic [1:0]    eresp;
        logic [31:0]   eaddr, ewdata;
        logic [3:0]    ebe;
    } vec_t;

    function automatic vec_t v(
        input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] be, input logic mw, input logic mrdv, input logic mwrv,
        input logic [31:0] mrdata, input logic [1:0] mresp, input logic [5:0] ectl,
        input logic [31:0] erdata, input logic [1:0] eresp, input logic [31:0] eaddr,
        input logic [31:0] ewdata, input logic [3:0] ebe);
        vec_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be;
        t.mw = mw; t.mrdv = mrdv; t.mwrv = mwrv; t.mrdata = mrdata; t.mresp = mresp;
        t.ectl = ectl; t.erdata = erdata; t.eresp = eresp;
        t.eaddr = eaddr; t.ewdata = ewdata; t.ebe = ebe;
        return t;
    endfunction

    task automatic set_idle();
        s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0; s_byteenable = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_writeresponsevalid = 1'b0;
        m_readdata = '0; m_response = 2'b00;
    endtask

    // Accept, slave takes it at once, data returned in the next cycle.
    task automatic quick_read(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] resp, input string nm);
        s_read = 1'b1; s_address = addr; m_waitrequest = 1'b0;
        @(negedge aclk);
        s_read = 1'b0;
        chk({nm, "_issue"}, {m_read, m_address}, {1'b1, addr});
        @(negedge aclk);
        m_readdatavalid = 1'b1; m_readdata = data; m_response = resp;
        @(negedge aclk);
        m_readdatavalid = 1'b0;
        chk({nm, "_ctl"}, ctl(), 6'b010000);
        chk({nm, "_rdata"}, s_readdata, data);
        chk({nm, "_resp"}, s_response, resp);
    endtask

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int  hi;
        bit  seen;

        // ---------------- vector table ----------------
        //            rd wr addr      wdata         be    mw mrdv mwrv mrdata        mresp  ectl       erdata        eresp  eaddr     ewdata        ebe
        tbl.push_back(v(1, 0, 32'h10, 32'h0,        4'hF, 1, 0, 0, 32'h0,        2'b00, 6'b000000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 0, 32'h0,        2'b00, 6'b100100, 32'h0,        2'b00, 32'h10, 32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 1, 0, 0, 32'h0,        2'b00, 6'b100100, 32'h0,        2'b00, 32'h10, 32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b100100, 32'h0,        2'b00, 32'h10, 32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 0, 32'hCAFE0001, 2'b00, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b010000, 32'hCAFE0001, 2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 1, 32'h20, 32'hA5A5A5A5, 4'h3, 0, 0, 0, 32'h0,        2'b00, 6'b000000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b100010, 32'h0,        2'b00, 32'h20, 32'hA5A5A5A5, 4'h3));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 0, 32'hDEADDEAD, 2'b00, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 1, 32'h0,        2'b10, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b001000, 32'h0,        2'b10, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(1, 0, 32'h30, 32'h0,        4'hF, 0, 0, 0, 32'h0,        2'b00, 6'b000000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b100100, 32'h0,        2'b00, 32'h30, 32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 0, 32'h12345678, 2'b01, 6'b100000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(1, 1, 32'h99, 32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b010000, 32'h12345678, 2'b01, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b010000, 32'h0,        2'b11, 32'h0,  32'h0,        4'h0));
        tbl.push_back(v(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 0, 32'h0,        2'b00, 6'b000000, 32'h0,        2'b00, 32'h0,  32'h0,        4'h0));

        // ---------------- reset state ----------------
        set_idle();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        chk("reset_ctl", ctl(), 6'b000000);
        chk("reset_rdata", s_readdata, 32'h0);
        chk("reset_resp", s_response, 2'b00);
        chk("reset_mcmd", {m_address, m_writedata, m_byteenable}, 64'h0);
        areset = 1'b0;
        @(negedge aclk);

        // ---------------- table-driven part ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t t;
            t = tbl[i];
            chk($sformatf("row%0d_ctl", i), ctl(), t.ectl);
            if (t.ectl[4] || t.ectl[3])
                chk($sformatf("row%0d_resp", i), s_response, t.eresp);
            if (t.ectl[4])
                chk($sformatf("row%0d_rdata", i), s_readdata, t.erdata);
            if (t.ectl[2] || t.ectl[1])
                chk($sformatf("row%0d_maddr", i), m_address, t.eaddr);
            if (t.ectl[1])
                chk($sformatf("row%0d_mwdata", i), {m_writedata, m_byteenable}, {t.ewdata, t.ebe});
            s_read = t.rd; s_write = t.wr; s_address = t.addr;
            s_writedata = t.wdata; s_byteenable = t.be;
            m_waitrequest = t.mw; m_readdatavalid = t.mrdv; m_writeresponsevalid = t.mwrv;
            m_readdata = t.mrdata; m_response = t.mresp;
            @(negedge aclk);
        end
        set_idle();
        @(negedge aclk);

        // ---------------- stuck waitrequest: timeout in ISSUE ----------------
        s_read = 1'b1; s_address = 32'h40; m_waitrequest = 1'b1;
        @(negedge aclk);
        s_read = 1'b0;
        hi = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (s_readdatavalid) begin
                seen = 1'b1;
                break;
            end
            if (m_read) hi++;
            @(negedge aclk);
        end
        chk("sto_seen", seen, 1'b1);
        chk("sto_mread_cycles", hi, TO);
        chk("sto_ctl", ctl(), 6'b010001);
        chk("sto_rdata", s_readdata, 32'h0);
        chk("sto_resp", s_response, 2'b10);
        m_waitrequest = 1'b0;
        @(negedge aclk);
        chk("sto_pulse_end", ctl(), 6'b000000);

        // ---------------- late response: timeout in RESPONSE, drain ----------------
        s_read = 1'b1; s_address = 32'h50; m_waitrequest = 1'b0;
        @(negedge aclk);                       // sample 1, ISSUE
        s_read = 1'b0;
        repeat (TO - 1) @(negedge aclk);       // sample 8, expiry cycle
        chk("late_pre_expiry", ctl(), 6'b100000);
        @(negedge aclk);                       // sample 9
        chk("late_err_ctl", ctl(), 6'b110001);
        chk("late_err_rdata", s_readdata, 32'h0);
        chk("late_err_resp", s_response, 2'b10);
        @(negedge aclk);                       // sample 10, still draining
        chk("late_drain_ctl", ctl(), 6'b100000);
        m_readdatavalid = 1'b1; m_readdata = 32'hBAD0BAD0; m_response = 2'b00;
        @(negedge aclk);
        m_readdatavalid = 1'b0;
        chk("late_discard_ctl", ctl(), 6'b000000);
        quick_read(32'h60, 32'h600D0003, 2'b00, "late_next");

        // ---------------- completion exactly in the expiry cycle ----------------
        @(negedge aclk);
        s_read = 1'b1; s_address = 32'h70; m_waitrequest = 1'b0;
        @(negedge aclk);
        s_read = 1'b0;
        repeat (TO - 1) @(negedge aclk);
        m_readdatavalid = 1'b1; m_readdata = 32'hBEEF0002; m_response = 2'b00;
        @(negedge aclk);
        m_readdatavalid = 1'b0;
        chk("edge_ctl", ctl(), 6'b010000);
        chk("edge_rdata", s_readdata, 32'hBEEF0002);
        chk("edge_resp", s_response, 2'b00);
        @(negedge aclk);
        chk("edge_after", ctl(), 6'b000000);

        // ---------------- asynchronous reset while in RESPONSE ----------------
        s_read = 1'b1; s_address = 32'h80; m_waitrequest = 1'b0;
        @(negedge aclk);
        s_read = 1'b0;
        @(negedge aclk);
        chk("rst_before", ctl(), 6'b100000);
        #2 areset = 1'b1;
        #1;
        chk("rst_async_ctl", ctl(), 6'b000000);
        chk("rst_async_data", {s_readdata, s_response, m_address[29:0]}, 64'h0);
        @(negedge aclk);
        areset = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h57A1E000; m_response = 2'b00;
        @(negedge aclk);
        m_readdatavalid = 1'b0;
        chk("rst_stale_ignored", ctl(), 6'b000000);
        quick_read(32'h90, 32'h0000C0DE, 2'b00, "rst_next");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
